// File: rtl/fp_pkg.sv
// Shared definitions for the shader-core FP datapath: op encoding and default
// operand format.
package fp_pkg;

  typedef enum logic [1:0] {
    FP_ADD = 2'b00,
    FP_MAX = 2'b01,
    FP_MIN = 2'b10,
    FP_SUB = 2'b11
  } fp_op_e;

  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 15;

  typedef struct packed {
    logic                sign;
    logic [FP_EXP_W-1:0] exp;
    logic [FP_MAN_W-1:0] man;
  } fp_t;

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero input reports 0 and must be
// detected separately by the caller.
module fp_lzc #(
  parameter  int W  = 20,
  localparam int CW = $clog2(W)
) (
  input  logic [W-1:0]  in_i,
  output logic [CW-1:0] cnt_o
);

  always_comb begin
    cnt_o = '0;
    // Scanning upward lets the most significant set bit win.
    for (int unsigned i = 0; i < W; i++) begin
      if (in_i[i]) cnt_o = CW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/fp_addsub_pipe.sv
// Three-stage FP add/sub/max/min with global-stall valid/ready handshake,
// truncating rounding, flush-to-zero and overflow-to-infinity.
module fp_addsub_pipe
  import fp_pkg::*;
#(
  parameter  int EXP_W = FP_EXP_W,
  parameter  int MAN_W = FP_MAN_W,
  parameter  int TAG_W = 4,
  localparam int WIDTH = 1 + EXP_W + MAN_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             ovf_o
);

  localparam int AW  = MAN_W + 4;
  localparam int SW  = MAN_W + 5;
  localparam int LZW = $clog2(SW);
  localparam int EW  = EXP_W + 2;
  localparam logic signed [EW-1:0] E_ONE  = EW'(1);
  localparam logic signed [EW-1:0] E_ZERO = '0;
  localparam logic signed [EW-1:0] E_MAX  = EW'((1 << EXP_W) - 1);

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } val_t;

  logic en;

  // Stage 1 combinational: decode, magnitude compare, align, max/min select.
  fp_op_e                   op;
  val_t                     a, b, mx, mn;
  logic                     a_zero, b_zero, mx_zero, mn_zero;
  logic                     a_is_max, b_gt_a, b_lt_a;
  logic [EXP_W+MAN_W-1:0]   mag_a, mag_b;
  logic [EXP_W-1:0]         diff;
  logic [AW-1:0]            mx_f_d, mn_f_d;
  logic                     pass_d, same_d;
  logic [WIDTH-1:0]         mm_res_d;

  always_comb begin
    op = fp_op_e'(op_i[1:0]);
    a  = a_i;
    b  = b_i;
    if (op == FP_SUB) b.sign = ~b.sign;
    a_zero   = (a.exp == '0);
    b_zero   = (b.exp == '0);
    mag_a    = a_zero ? '0 : {a.exp, a.man};
    mag_b    = b_zero ? '0 : {b.exp, b.man};
    a_is_max = (mag_a >= mag_b);
    mx       = a_is_max ? a : b;
    mn       = a_is_max ? b : a;
    mx_zero  = a_is_max ? a_zero : b_zero;
    mn_zero  = a_is_max ? b_zero : a_zero;
    same_d   = (mx.sign == mn.sign);
    diff     = mx.exp - mn.exp;
    mx_f_d   = mx_zero ? '0 : {1'b1, mx.man, 3'b000};
    mn_f_d   = mn_zero ? '0 : {1'b1, mn.man, 3'b000};
    if (32'(diff) >= 32'(AW)) mn_f_d = '0;
    else                      mn_f_d = mn_f_d >> diff;

    if (a.sign != b.sign) begin
      b_gt_a = ~b.sign;
      b_lt_a = b.sign;
    end else if (!a.sign) begin
      b_gt_a = (mag_b > mag_a);
      b_lt_a = (mag_b < mag_a);
    end else begin
      b_gt_a = (mag_b < mag_a);
      b_lt_a = (mag_b > mag_a);
    end
    pass_d   = (op == FP_MAX) || (op == FP_MIN);
    mm_res_d = (op == FP_MAX) ? (b_gt_a ? b_i : a_i) : (b_lt_a ? b_i : a_i);
  end

  logic             s1_valid_q, s1_pass_q, s1_same_q, s1_sign_q;
  logic [TAG_W-1:0] s1_tag_q;
  logic [WIDTH-1:0] s1_res_q;
  logic [EXP_W-1:0] s1_exp_q;
  logic [AW-1:0]    s1_mx_q, s1_mn_q;

  // Stage 2 combinational: magnitude add or subtract.
  logic [SW-1:0] sum_d;

  always_comb begin
    if (s1_same_q) sum_d = {1'b0, s1_mx_q} + {1'b0, s1_mn_q};
    else           sum_d = {1'b0, s1_mx_q} - {1'b0, s1_mn_q};
  end

  logic             s2_valid_q, s2_pass_q, s2_same_q, s2_sign_q;
  logic [TAG_W-1:0] s2_tag_q;
  logic [WIDTH-1:0] s2_res_q;
  logic [EXP_W-1:0] s2_exp_q;
  logic [SW-1:0]    s2_sum_q;

  // Stage 3 combinational: normalise and pack.
  logic [LZW-1:0]       lzc;
  logic [SW-1:0]        sh;
  logic signed [EW-1:0] e;
  logic [WIDTH-1:0]     res_d;
  logic                 ovf_d;
  logic                 unused_bits;

  fp_lzc #(.W(SW)) u_lzc (
    .in_i  (s2_sum_q),
    .cnt_o (lzc)
  );

  // Counting from the carry bit folds the carry case (lzc=0 -> exp+1) and the
  // left-normalise case (exp+1-lzc) into one shift and one exponent update.
  always_comb begin
    sh    = s2_sum_q << lzc;
    e     = $signed({2'b00, s2_exp_q}) + E_ONE - $signed({{(EW-LZW){1'b0}}, lzc});
    ovf_d = 1'b0;
    if (s2_pass_q) begin
      res_d = s2_res_q;
    end else if (s2_sum_q == '0) begin
      res_d = {s2_same_q & s2_sign_q, {(WIDTH-1){1'b0}}};
    end else if (e >= E_MAX) begin
      res_d = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      ovf_d = 1'b1;
    end else if (e <= E_ZERO) begin
      res_d = {s2_sign_q, {(WIDTH-1){1'b0}}};
    end else begin
      res_d = {s2_sign_q, e[EXP_W-1:0], sh[SW-2 -: MAN_W]};
    end
  end

  assign unused_bits = ^{op_i[3:2], sh[SW-1], sh[SW-2-MAN_W:0]};

  logic             valid_q, ovf_q;
  logic [WIDTH-1:0] res_q;
  logic [TAG_W-1:0] tag_q;

  assign en       = ~valid_q | ready_i;
  assign ready_o  = en;
  assign valid_o  = valid_q;
  assign result_o = res_q;
  assign tag_o    = tag_q;
  assign ovf_o    = ovf_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0; s1_pass_q <= 1'b0; s1_same_q <= 1'b0; s1_sign_q <= 1'b0;
      s1_tag_q   <= '0;   s1_res_q  <= '0;   s1_exp_q  <= '0;
      s1_mx_q    <= '0;   s1_mn_q   <= '0;
      s2_valid_q <= 1'b0; s2_pass_q <= 1'b0; s2_same_q <= 1'b0; s2_sign_q <= 1'b0;
      s2_tag_q   <= '0;   s2_res_q  <= '0;   s2_exp_q  <= '0;   s2_sum_q  <= '0;
      valid_q    <= 1'b0; ovf_q     <= 1'b0; res_q     <= '0;   tag_q     <= '0;
    end else if (en) begin
      s1_valid_q <= valid_i;
      s1_pass_q  <= pass_d;
      s1_same_q  <= same_d;
      s1_sign_q  <= mx.sign;
      s1_tag_q   <= tag_i;
      s1_res_q   <= mm_res_d;
      s1_exp_q   <= mx.exp;
      s1_mx_q    <= mx_f_d;
      s1_mn_q    <= mn_f_d;

      s2_valid_q <= s1_valid_q;
      s2_pass_q  <= s1_pass_q;
      s2_same_q  <= s1_same_q;
      s2_sign_q  <= s1_sign_q;
      s2_tag_q   <= s1_tag_q;
      s2_res_q   <= s1_res_q;
      s2_exp_q   <= s1_exp_q;
      s2_sum_q   <= sum_d;

      valid_q    <= s2_valid_q;
      ovf_q      <= ovf_d;
      res_q      <= res_d;
      tag_q      <= s2_tag_q;
    end
  end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Scoreboard bench for fp_addsub_pipe: directed ops push expected results,
// a negedge monitor pops and compares whenever a result transfers.
module tb_fp_addsub_pipe;
  import fp_pkg::*;

  localparam int W = 24;

  logic          clk = 1'b0;
  logic          rst_i, valid_i, ready_i;
  logic          ready_o, valid_o, ovf_o;
  logic [3:0]    op_i, tag_i, tag_o;
  logic [W-1:0]  a_i, b_i, result_o;

  typedef struct {
    logic [W-1:0] res;
    logic [3:0]   tag;
    logic         ovf;
    int           acc;
    bit           lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  fp_addsub_pipe #(.EXP_W(8), .MAN_W(15), .TAG_W(4)) dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .op_i     (op_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .tag_i    (tag_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .result_o (result_o),
    .tag_o    (tag_o),
    .ovf_o    (ovf_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at cycle %0d", name, act, expv, cyc);
    end
  endtask

  task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [3:0] tag, input logic [W-1:0] er, input logic eo,
                      input bit chk_lat);
    int n = 0;
    op_i = op; a_i = a; b_i = b; tag_i = tag; valid_i = 1'b1;
    while (!ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!ready_o) begin
      failures++;
      $display("FAIL send_timeout tag=%h ready_o stayed %b", tag, ready_o);
    end else begin
      sb.push_back('{res: er, tag: tag, ovf: eo, acc: cyc, lat: chk_lat});
    end
    @(negedge clk);
    valid_i = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", sb.size(), 0);
  endtask

  // Monitor: compares each transferred result and checks stall stability.
  initial begin
    exp_t         e;
    bit           stall_prev = 0;
    logic [W-1:0] prev_res;
    logic [3:0]   prev_tag;
    logic         prev_ovf;
    forever begin
      @(negedge clk);
      if (!rst_i) begin
        if (stall_prev) begin
          chk("stall_valid_o", valid_o, 1);
          chk("stall_result_o", result_o, prev_res);
          chk("stall_tag_o", tag_o, prev_tag);
          chk("stall_ovf_o", ovf_o, prev_ovf);
        end
        if (valid_o && !ready_i) chk("stall_ready_o", ready_o, 0);
        if (valid_o && ready_i) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output result=%h tag=%h", result_o, tag_o);
          end else begin
            e = sb.pop_front();
            chk("result", result_o, e.res);
            chk("tag", tag_o, e.tag);
            chk("ovf", ovf_o, e.ovf);
            if (e.lat) chk("latency", cyc - e.acc, 3);
          end
        end
        stall_prev = valid_o && !ready_i;
        prev_res = result_o; prev_tag = tag_o; prev_ovf = ovf_o;
      end else begin
        stall_prev = 0;
      end
    end
  end

  initial begin
    rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
    op_i = '0; a_i = '0; b_i = '0; tag_i = '0;
    repeat (3) @(negedge clk);
    chk("reset_valid_o", valid_o, 0);
    chk("reset_result_o", result_o, 0);
    chk("reset_tag_o", tag_o, 0);
    chk("reset_ovf_o", ovf_o, 0);
    rst_i = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", ready_o, 1);

    send({2'b00, FP_ADD}, 24'h3F8000, 24'h3F0000, 4'h5, 24'h3FC000, 1'b0, 1);
    send({2'b00, FP_SUB}, 24'h3FC000, 24'h3F8000, 4'h6, 24'h3F0000, 1'b0, 1);
    send({2'b00, FP_SUB}, 24'h3F8000, 24'h3F8000, 4'h7, 24'h000000, 1'b0, 1);
    send({2'b00, FP_MAX}, 24'hC00000, 24'h3F8000, 4'h8, 24'h3F8000, 1'b0, 1);
    send({2'b00, FP_MIN}, 24'hC00000, 24'h3F8000, 4'h9, 24'hC00000, 1'b0, 1);
    send({2'b00, FP_MIN}, 24'h800000, 24'h000000, 4'hA, 24'h800000, 1'b0, 1);
    send({2'b00, FP_ADD}, 24'h7F7FFF, 24'h7F7FFF, 4'hB, 24'h7F8000, 1'b1, 1);
    send({2'b00, FP_SUB}, 24'h008001, 24'h008000, 4'hC, 24'h000000, 1'b0, 1);
    send({2'b00, FP_ADD}, 24'h000000, 24'h3FC000, 4'hD, 24'h3FC000, 1'b0, 1);
    send({2'b00, FP_ADD}, 24'h800000, 24'h800000, 4'hE, 24'h800000, 1'b0, 1);
    send({2'b00, FP_ADD}, 24'h000000, 24'h800000, 4'hF, 24'h000000, 1'b0, 1);
    send({2'b00, FP_ADD}, 24'h000123, 24'h3F8000, 4'h0, 24'h3F8000, 1'b0, 1);
    send({2'b00, FP_ADD}, 24'h3F8000, 24'h2F8000, 4'h1, 24'h3F8000, 1'b0, 1);
    send({2'b11, FP_MAX}, 24'h3F0000, 24'h3F8000, 4'h2, 24'h3F8000, 1'b0, 1);
    wait_drain();

    // Back-to-back stream with downstream stalled for five cycles.
    fork
      begin
        send({2'b00, FP_ADD}, 24'h3F8000, 24'h3F8000, 4'h1, 24'h400000, 1'b0, 0);
        send({2'b00, FP_ADD}, 24'h400000, 24'h3F8000, 4'h2, 24'h404000, 1'b0, 0);
        send({2'b00, FP_ADD}, 24'h3FC000, 24'h3F0000, 4'h3, 24'h400000, 1'b0, 0);
        send({2'b00, FP_ADD}, 24'hBF8000, 24'h3F0000, 4'h4, 24'hBF0000, 1'b0, 0);
      end
      begin
        repeat (3) @(posedge clk);
        #2 ready_i = 1'b0;
        repeat (5) @(posedge clk);
        #2 ready_i = 1'b1;
      end
    join
    wait_drain();

    // Reset with two operations in flight discards both.
    send({2'b00, FP_ADD}, 24'h3F8000, 24'h3F8000, 4'h3, 24'h400000, 1'b0, 1);
    send({2'b00, FP_ADD}, 24'h3F8000, 24'h3F0000, 4'h4, 24'h3FC000, 1'b0, 1);
    rst_i = 1'b1;
    sb.delete();
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("no_output_after_reset", valid_o, 0);
    end
    send({2'b00, FP_ADD}, 24'h3F8000, 24'h3F0000, 4'h9, 24'h3FC000, 1'b0, 1);
    wait_drain();
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp_addsub_pipe.md
Name: fp_addsub_pipe

Overview:
- Parametrised, fully pipelined floating-point add/sub/max/min unit for the shader core FP datapath; next generation of the current fixed 24-bit (1-8-15) single-stage normaliser.
- Covers operand alignment, add/subtract, leading-zero normalisation and packing over three stages.
- Adds explicit subtract, valid/ready back-pressure, zero/overflow/underflow handling and a pass-through tag.

Parameters:
EXP_W, 8, exponent field width; bias = 2^(EXP_W-1)-1
MAN_W, 15, stored mantissa width (hidden 1 implied)
WIDTH, 1+EXP_W+MAN_W, total operand width (derived, not overridden)
TAG_W, 4, width of the sideband tag carried alongside each operation

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
valid_i  in  1  input operation valid
ready_o  out  1  unit can accept input this cycle
op_i  in  4  [1:0]: 00 add, 01 max, 10 min, 11 sub (a-b); [3:2] reserved, ignored
a_i  in  WIDTH  operand A {sign, exp, man}
b_i  in  WIDTH  operand B
tag_i  in  TAG_W  sideband tag
valid_o  out  1  result valid
ready_i  in  1  downstream accepts result
result_o  out  WIDTH  result
tag_o  out  TAG_W  tag of the result
ovf_o  out  1  result overflowed to infinity (qualified by valid_o)

Behaviour:
- One clock domain. Reset is synchronous and active-high: clk_i, rst_i.
- Reset: all stage valids = 0, valid_o = 0, ovf_o = 0, result_o = 0, tag_o = 0. ready_o = 1 the cycle after reset deasserts.
- Reset asserted mid-operation discards all in-flight operations. No output is produced for them.
- Global stall: en = ~valid_o | ready_i, and ready_o = en.
  - When en = 0, every pipeline register holds.
  - Bubbles are not collapsed.
  - Transfer happens on valid & ready at both ends.
- Latency is exactly 3 cycles from an accepted input to valid_o when unstalled. Throughput is 1 op per cycle.
- While valid_o = 1 and ready_i = 0, result_o, tag_o and ovf_o are stable.
- Decoding:
  - sub inverts b's sign before stage 1.
  - Any operand with exp == 0 is treated as signed zero; its mantissa is ignored (denormals flushed).
  - exp == all-ones is treated as an ordinary value; no NaN semantics.
- Stage 1 (align):
  - Compare {exp, man} magnitudes. Larger operand → max, smaller → min; on a tie A is max.
  - Shift min's {1, man} right by the exponent difference into a MAN_W+4 bit field with 3 guard bits.
  - A difference ≥ MAN_W+4 yields 0.
  - max/min ops resolve their result here as a signed compare: -x < +y; +0 > -0; equal values return A. The result is then passed through unmodified.
- Stage 2 (add): if signs are equal, add the aligned mantissas (1 carry bit); otherwise subtract min from max (result ≥ 0). Result sign = max sign.
- Stage 3 (normalise/pack):
  - On carry: shift right 1 and set exp+1.
  - Otherwise: lzc = leading-zero count; shift left by lzc and set exp-lzc.
  - Rounding is truncation (round toward zero); guard bits are dropped.
  - Exact cancellation (mantissa sum 0) → +0, all bits zero.
  - Exponent result ≥ 2^EXP_W-1 → {sign, all-ones, 0} with ovf_o = 1.
  - Exponent result ≤ 0 → {sign, 0, 0} (flush to zero).
  - Zero + x → x exactly. Zero + zero → +0, except (-0)+(-0) → -0.
- tag is carried unchanged with its op.
- Widths:
  - Exponent arithmetic is done in EXP_W+2 bits signed to detect both overflow and underflow.
  - The lzc width is clog2(MAN_W+5).

Decomposition:
- Package fp_pkg:
  - op enum fp_op_e (FP_ADD=00, FP_MAX=01, FP_MIN=10, FP_SUB=11).
  - Format default constants FP_EXP_W, FP_MAN_W.
  - Packed struct for the {sign, exp, man} operand, parametrised via localparams.
- Sub-module fp_lzc #(.W) is a combinational leading-zero counter used by stage 3. It replaces the hand-written casez priority chain and is reused by future mul/div units.

Test Plan:
- add 0x3F8000 (1.0) + 0x3F0000 (0.5), tag 5 → after 3 cycles result 0x3FC000 (1.5), tag_o 5, ovf_o 0.
- sub 0x3FC000 − 0x3F8000 → 0x3F0000. Then sub 0x3F8000 − 0x3F8000 → 0x000000 (cancellation to +0).
- max(0xC00000 (−2.0), 0x3F8000) → 0x3F8000. min of the same → 0xC00000. min(0x800000 (−0), 0x000000) → 0x800000.
- add 0x7F7FFF + 0x7F7FFF → 0x7F8000 with ovf_o 1. Also sub 0x008001 − 0x008000 → 0x000000 (underflow flush).
- Back-to-back stream: 4 adds with ready_i held low for cycles 4–8.
  - valid_o is high and result_o stays stable through the stall; ready_o = 0.
  - All 4 results emerge in order with correct tags.
- Assert rst_i with 2 ops in flight → no valid_o afterwards. Next op accepted post-reset returns with 3-cycle latency.
